osc_sweep_monitor: RTL and testbench
====================================

// Module: osc_sweep_monitor
// PURPOSE
//  Receive-side counterpart of the combinational-loop stimulus sweep: drives every input vector into the
//  DUT logic cone, then observes one DUT net for sustained toggling. Compares detected oscillation with
//  the predicted OscFlag and reports per-vector results over a valid/ready channel.
//  Sits beside the combLogic instance; replaces free-running tb toggling with a clocked, checkable sweep.
// PARAMETERS
//  VEC_W       8   width of swept input vector (sweep covers 0 .. 2**VEC_W-1)
//  SETTLE_CYC  4   cycles vector is held before observation starts (>=1)
//  WINDOW_CYC  16  observation window length in cycles (>=2)
//  TOGGLE_THR  2   edge count >= this => oscillation detected (>=1)
//  CNT_W       5   edge counter width; saturates at 2**CNT_W-1
// PORTS
//  clk            in   1      single clock
//  rst_n          in   1      asynchronous active-low reset
//  start          in   1      start sweep; sampled only in IDLE
//  vec_out        out  VEC_W  vector driven to DUT inputs
//  obs_net        in   1      observed DUT net, asynchronous to clk
//  osc_flag_pred  in   1      predicted oscillation flag for current vec_out
//  busy           out  1      high from start accept until sweep end
//  done           out  1      one-cycle pulse after last vector completes
//  rpt_valid      out  1      report available
//  rpt_ready      in   1      consumer accepts report
//  rpt_vec        out  VEC_W  vector of this report
//  rpt_osc        out  1      oscillation detected for rpt_vec
//  rpt_mismatch   out  1      rpt_osc != sampled osc_flag_pred
//  mismatch_cnt   out  16     saturating count of mismatching vectors in current sweep
// BEHAVIOUR
//  Reset: vec_out=0, busy=0, done=0, rpt_valid=0, rpt_vec=0, rpt_osc=0, rpt_mismatch=0,
//    mismatch_cnt=0, state=IDLE, sync flops=0, edge count=0. Reset mid-sweep aborts immediately; no done.
//  FSM: IDLE -> SETTLE (start=1; vec_out=0, busy=1, mismatch_cnt=0 in same edge).
//    SETTLE: SETTLE_CYC cycles, edge counter held at 0 -> OBSERVE.
//    OBSERVE: WINDOW_CYC cycles, counting edges of synchronised obs_net; on last cycle capture
//      rpt_vec/rpt_osc/rpt_mismatch, osc_flag_pred sampled on that cycle -> REPORT or NEXT.
//    REPORT: rpt_valid=1, fields stable until rpt_valid&&rpt_ready; transfer -> NEXT.
//    NEXT: vec_out==all-ones -> IDLE with done=1, busy=0; else vec_out+=1 -> SETTLE.
//  obs_net: 2-flop synchroniser; edge = sync[1]^prev; edges in SETTLE ignored.
//  Edge counter saturates at 2**CNT_W-1, never wraps. mismatch_cnt saturates at 16'hFFFF.
//  mismatch_cnt increments on the OBSERVE capture cycle when mismatch=1 (independent of reporting).
//  start while busy ignored. rpt_ready while !rpt_valid ignored. vec_out wraps only at sweep end.
//  Per-vector latency without report stall: SETTLE_CYC+WINDOW_CYC+1(+1 if REPORT, with ready=1).
// CONFIGURATION
//  OSC_REPORT_ALL_EN defined: every vector enters REPORT (2**VEC_W reports per sweep).
//  Not defined: REPORT entered only when mismatch=1; matching vectors go OBSERVE -> NEXT.
// STRUCTURE
//  Package osc_pkg: state enum (IDLE,SETTLE,OBSERVE,REPORT,NEXT), default parameter constants,
//    report struct {vec, osc, mismatch}.
//  Sub-module osc_edge_counter: synchroniser, edge detect, clear/enable, saturating CNT_W counter.
// TESTING (VEC_W=3, SETTLE_CYC=4, WINDOW_CYC=16, TOGGLE_THR=2)
//  obs_net const 0, pred=0, REPORT_ALL, ready=1 -> 8 reports vec 0..7, rpt_osc=0, mismatch_cnt=0, one done.
//  obs_net toggles every cycle only for vec 5, pred=1 for vec 5 -> rpt_osc=1 at vec 5, no mismatch.
//  Same, pred=0 everywhere, REPORT_ALL off -> exactly one report (vec 5, mismatch=1), mismatch_cnt=1.
//  rpt_ready held 0 for 10 cycles at vec 2 -> rpt_valid/fields stable, vec_out stays 2, no skipped vector.
//  rst_n low during OBSERVE of vec 4 -> all outputs reset values at once; no done; new start begins at 0.
//  Single obs_net pulse in window (1 edge... 2 edges) -> rpt_osc=1 at 2 edges, 0 at 1 edge; start while busy ignored.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types and default constants for the oscillation sweep monitor.
package osc_pkg;

    localparam int VEC_W_DEF      = 8;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int WINDOW_CYC_DEF = 16;
    localparam int TOGGLE_THR_DEF = 2;
    localparam int CNT_W_DEF      = 5;
    localparam int RPT_VEC_MAX    = 16;
    localparam int MCNT_W         = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        OBSERVE,
        REPORT,
        NEXT
    } osc_state_t;

    // The vector field is sized for the widest supported sweep; narrower sweeps zero-extend.
    typedef struct packed {
        logic [RPT_VEC_MAX-1:0] vec;
        logic                   osc;
        logic                   mismatch;
    } osc_rpt_t;

    function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] v);
        return (v == {MCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/osc_edge_counter.sv
// Synchronises the observed net, detects its edges and counts them with saturation.
module osc_edge_counter
    import osc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             obs_net,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_next
);

    logic             sync0_q;
    logic             sync1_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= obs_net;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    // prev_q tracks continuously so edges arriving while cleared are consumed, not deferred.
    always_comb begin
        edge_det = sync1_q ^ prev_q;
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && edge_det && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign cnt_next = cnt_d;

endmodule

// File: rtl/osc_sweep_monitor.sv
// Clocked input-vector sweep that checks observed oscillation against a predicted flag.
// Define OSC_REPORT_ALL_EN to report every vector; otherwise only mismatching vectors are reported.
module osc_sweep_monitor
    import osc_pkg::*;
#(
    parameter int VEC_W      = VEC_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int WINDOW_CYC = WINDOW_CYC_DEF,
    parameter int TOGGLE_THR = TOGGLE_THR_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] vec_out,
    input  logic             obs_net,
    input  logic             osc_flag_pred,
    output logic             busy,
    output logic             done,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [VEC_W-1:0] rpt_vec,
    output logic             rpt_osc,
    output logic             rpt_mismatch,
    output logic [15:0]      mismatch_cnt
);

`ifdef OSC_REPORT_ALL_EN
    localparam bit REPORT_ALL = 1'b1;
`else
    localparam bit REPORT_ALL = 1'b0;
`endif

    localparam int PH_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    osc_state_t        state_q, state_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rpt_valid_q, rpt_valid_d;
    logic [VEC_W-1:0]  rpt_vec_q, rpt_vec_d;
    logic              rpt_osc_q, rpt_osc_d;
    logic              rpt_mismatch_q, rpt_mismatch_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;

    logic [CNT_W-1:0]  cnt_next;
    logic              osc_now;
    logic              mismatch_now;
    logic              observing;

    assign observing = (state_q == OBSERVE);

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .obs_net  (obs_net),
        .clr      (!observing),
        .en       (observing),
        .cnt_next (cnt_next)
    );

    // Decision includes an edge landing on the capture cycle itself.
    assign osc_now      = (32'(cnt_next) >= 32'(TOGGLE_THR));
    assign mismatch_now = osc_now ^ osc_flag_pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vec_q          <= '0;
            phase_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rpt_valid_q    <= 1'b0;
            rpt_vec_q      <= '0;
            rpt_osc_q      <= 1'b0;
            rpt_mismatch_q <= 1'b0;
            mcnt_q         <= '0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            phase_q        <= phase_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            rpt_valid_q    <= rpt_valid_d;
            rpt_vec_q      <= rpt_vec_d;
            rpt_osc_q      <= rpt_osc_d;
            rpt_mismatch_q <= rpt_mismatch_d;
            mcnt_q         <= mcnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        phase_d        = phase_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        rpt_valid_d    = rpt_valid_q;
        rpt_vec_d      = rpt_vec_q;
        rpt_osc_d      = rpt_osc_q;
        rpt_mismatch_d = rpt_mismatch_q;
        mcnt_d         = mcnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    vec_d   = '0;
                    phase_d = '0;
                    busy_d  = 1'b1;
                    mcnt_d  = '0;
                end
            end
            SETTLE: begin
                if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
                    phase_d = '0;
                    state_d = OBSERVE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            OBSERVE: begin
                if (phase_q == PH_W'(WINDOW_CYC - 1)) begin
                    phase_d        = '0;
                    rpt_vec_d      = vec_q;
                    rpt_osc_d      = osc_now;
                    rpt_mismatch_d = mismatch_now;
                    if (mismatch_now) begin
                        mcnt_d = sat_inc(mcnt_q);
                    end
                    if (REPORT_ALL || mismatch_now) begin
                        state_d     = REPORT;
                        rpt_valid_d = 1'b1;
                    end else begin
                        state_d = NEXT;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    rpt_valid_d = 1'b0;
                    state_d     = NEXT;
                end
            end
            NEXT: begin
                if (vec_q == {VEC_W{1'b1}}) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vec_out      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rpt_valid    = rpt_valid_q;
    assign rpt_vec      = rpt_vec_q;
    assign rpt_osc      = rpt_osc_q;
    assign rpt_mismatch = rpt_mismatch_q;
    assign mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_osc_sweep_monitor.sv
// Directed sweeps against osc_sweep_monitor with a queue of expected reports.
module tb_osc_sweep_monitor;
    import osc_pkg::*;

    localparam int VW = 3;
    localparam int SC = 4;
    localparam int WC = 16;
    localparam int TT = 2;

`ifdef OSC_REPORT_ALL_EN
    localparam bit REPORT_ALL = 1'b1;
`else
    localparam bit REPORT_ALL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic          obs_net = 1'b0;
    logic          rpt_ready = 1'b1;
    logic [VW-1:0] vec_out;
    logic [VW-1:0] rpt_vec;
    logic          osc_flag_pred;
    logic          busy;
    logic          done;
    logic          rpt_valid;
    logic          rpt_osc;
    logic          rpt_mismatch;
    logic [15:0]   mismatch_cnt;

    // Stimulus configuration: 0 quiet, 1 toggle every cycle, 2 two-edge pulse, 3 single step.
    int            tog_mode = 0;
    logic [VW-1:0] tv = '0;
    logic [7:0]    pred_mask = '0;

    int errors = 0;
    int checks = 0;
    osc_rpt_t exp_q[$];

    always #5 clk = ~clk;

    assign osc_flag_pred = pred_mask[vec_out];

    osc_sweep_monitor #(
        .VEC_W      (VW),
        .SETTLE_CYC (SC),
        .WINDOW_CYC (WC),
        .TOGGLE_THR (TT),
        .CNT_W      (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .vec_out       (vec_out),
        .obs_net       (obs_net),
        .osc_flag_pred (osc_flag_pred),
        .busy          (busy),
        .done          (done),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_vec       (rpt_vec),
        .rpt_osc       (rpt_osc),
        .rpt_mismatch  (rpt_mismatch),
        .mismatch_cnt  (mismatch_cnt)
    );

    initial begin : obs_drv
        logic [VW-1:0] last_vec;
        int vcyc;
        last_vec = '0;
        vcyc = 0;
        forever begin
            @(negedge clk);
            if (vec_out !== last_vec || !busy) vcyc = 0;
            else vcyc++;
            last_vec = vec_out;
            case (tog_mode)
                1: obs_net = (busy && vec_out == tv) ? ~obs_net : 1'b0;
                2: obs_net = (busy && vec_out == tv && vcyc >= 8 && vcyc < 11);
                3: obs_net = (busy && vec_out == tv && vcyc >= 8);
                default: obs_net = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_vec_out"}, 32'(vec_out), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_rpt_valid"}, 32'(rpt_valid), 0);
        check({pfx, "_rpt_vec"}, 32'(rpt_vec), 0);
        check({pfx, "_rpt_osc"}, 32'(rpt_osc), 0);
        check({pfx, "_rpt_mismatch"}, 32'(rpt_mismatch), 0);
        check({pfx, "_mismatch_cnt"}, 32'(mismatch_cnt), 0);
    endtask

    task automatic push_expected();
        for (int v = 0; v < (1 << VW); v++) begin
            osc_rpt_t r;
            r.vec      = RPT_VEC_MAX'(v);
            r.osc      = (tog_mode == 1 || tog_mode == 2) && (v == int'(tv));
            r.mismatch = r.osc ^ pred_mask[v];
            if (REPORT_ALL || r.mismatch) exp_q.push_back(r);
        end
    endtask

    task automatic run_sweep(input int exp_mis, input bit stall_v2, input bit poke_start);
        bit seen_done;
        bit stalled;
        seen_done = 1'b0;
        stalled = 1'b0;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on_start", 32'(busy), 1);
        check("vec_on_start", 32'(vec_out), 0);
        check("mcnt_on_start", 32'(mismatch_cnt), 0);
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (poke_start && cyc == 60) start = 1'b1;
            if (poke_start && cyc == 61) begin
                start = 1'b0;
                check("busy_ignore_start", 32'(busy), 1);
            end
            if (done) begin
                seen_done = 1'b1;
                check("busy_clear_at_done", 32'(busy), 0);
                check("queue_drained", 32'(exp_q.size()), 0);
                check("mismatch_cnt_end", 32'(mismatch_cnt), 32'(exp_mis));
                @(negedge clk);
                check("done_one_cycle", 32'(done), 0);
            end else begin
                if (stall_v2 && !stalled && rpt_valid && rpt_vec == 3'd2) begin
                    rpt_ready = 1'b0;
                    stalled = 1'b1;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        check("stall_valid", 32'(rpt_valid), 1);
                        check("stall_rpt_vec", 32'(rpt_vec), 2);
                        check("stall_vec_out", 32'(vec_out), 2);
                    end
                    rpt_ready = 1'b1;
                end
                if (rpt_valid && rpt_ready) begin
                    check("rpt_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        osc_rpt_t e;
                        e = exp_q.pop_front();
                        check("rpt_vec", 32'(rpt_vec), 32'(e.vec));
                        check("rpt_osc", 32'(rpt_osc), 32'(e.osc));
                        check("rpt_mismatch", 32'(rpt_mismatch), 32'(e.mismatch));
                        $display("report vec=%0d osc=%0b mismatch=%0b", rpt_vec, rpt_osc, rpt_mismatch);
                    end
                end
            end
        end
        if (!seen_done) check("sweep_timeout", 32'(seen_done), 1);
        if (stall_v2) check("stall_happened", 32'(stalled), 1);
        exp_q.delete();
    endtask

    initial begin : main
        bit hit;
        bit saw_done;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Quiet net, nothing predicted.
        tog_mode = 0; pred_mask = 8'h00;
        run_sweep(0, 1'b0, 1'b0);

        // Toggling on vec 5, correctly predicted.
        tog_mode = 1; tv = 3'd5; pred_mask = 8'h20;
        run_sweep(0, 1'b0, 1'b0);

        // Toggling on vec 5, not predicted.
        pred_mask = 8'h00;
        run_sweep(1, 1'b0, 1'b0);

        // Mismatch at vec 2 with consumer back-pressure.
        tog_mode = 0; pred_mask = 8'h04;
        run_sweep(1, 1'b1, 1'b0);

        // Abort mid-OBSERVE of vec 4.
        tog_mode = 0; pred_mask = 8'h02;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            if (vec_out == 3'd4) hit = 1'b1;
        end
        check("reached_vec4", 32'(hit), 1);
        repeat (SC + 6) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 1);
        check("pre_reset_mcnt", 32'(mismatch_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_abort", 32'(saw_done), 0);
        check("idle_after_abort", 32'(busy), 0);

        // Two-edge pulse on vec 3, unpredicted, with a start poke mid-sweep.
        tog_mode = 2; tv = 3'd3; pred_mask = 8'h00;
        run_sweep(1, 1'b0, 1'b1);

        // Single edge on vec 3 is below threshold, but predicted as oscillating.
        tog_mode = 3; tv = 3'd3; pred_mask = 8'h08;
        run_sweep(1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
